// File: rtl/fpu_op_sequencer.sv
// Feeds a batch of operand pairs from a synchronous operand store into an FP ALU,
// one operation in flight at a time, and forwards each result tagged with its store index.
module fpu_op_sequencer #(
  parameter int IDX_W = 4,
  parameter int TO_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IDX_W-1:0] first_idx,
  input  logic [IDX_W-1:0] num_ops,
  input  logic [1:0]       op_sel,
  output logic [IDX_W-1:0] rom_addr,
  input  logic [31:0]      rom_a,
  input  logic [31:0]      rom_b,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [1:0]       alu_op,
  output logic             alu_valid,
  input  logic             alu_ready,
  input  logic             alu_res_valid,
  input  logic [31:0]      alu_res,
  output logic             res_valid,
  output logic [31:0]      res_data,
  output logic [IDX_W-1:0] res_idx,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Watchdog value whose increment reaches the all-ones terminal count.
  localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};
  localparam logic [TO_W-1:0] WD_TERM = {TO_W{1'b1}};

  logic [2:0]       state_q, state_d;
  logic             start_prev_q, start_prev_d;
  logic [IDX_W-1:0] cur_q, cur_d;
  logic [IDX_W-1:0] rem_q, rem_d;
  logic [1:0]       op_q, op_d;
  logic [31:0]      alu_a_q, alu_a_d;
  logic [31:0]      alu_b_q, alu_b_d;
  logic             alu_valid_q, alu_valid_d;
  logic             res_valid_q, res_valid_d;
  logic [31:0]      res_data_q, res_data_d;
  logic [IDX_W-1:0] res_idx_q, res_idx_d;
  logic [TO_W-1:0]  wd_q, wd_d;
  logic             timeout_q, timeout_d;
  logic             accept;

  assign accept = start && !start_prev_q && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d      = state_q;
    start_prev_d = start;
    cur_d        = cur_q;
    rem_d        = rem_q;
    op_d         = op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_valid_d  = alu_valid_q;
    res_valid_d  = 1'b0;
    res_data_d   = res_data_q;
    res_idx_d    = res_idx_q;
    wd_d         = wd_q;
    timeout_d    = timeout_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          cur_d     = first_idx;
          rem_d     = num_ops;
          op_d      = op_sel;
          timeout_d = 1'b0;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        alu_a_d     = rom_a;
        alu_b_d     = rom_b;
        alu_valid_d = 1'b1;
        state_d     = S_ISSUE;
      end
      S_ISSUE: begin
        if (alu_ready) begin
          alu_valid_d = 1'b0;
          wd_d        = '0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        // A result arriving on the terminal-count cycle takes priority over the timeout.
        if (alu_res_valid) begin
          res_valid_d = 1'b1;
          res_data_d  = alu_res;
          res_idx_d   = cur_q;
          if (rem_q == '0) begin
            state_d = S_DONE;
          end else begin
            cur_d   = cur_q + 1'b1;
            rem_d   = rem_q - 1'b1;
            state_d = S_FETCH;
          end
        end else if (wd_q == WD_LAST) begin
          wd_d      = WD_TERM;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b0;
      cur_q        <= '0;
      rem_q        <= '0;
      op_q         <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_valid_q  <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_idx_q    <= '0;
      wd_q         <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      cur_q        <= cur_d;
      rem_q        <= rem_d;
      op_q         <= op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_valid_q  <= alu_valid_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_idx_q    <= res_idx_d;
      wd_q         <= wd_d;
      timeout_q    <= timeout_d;
    end
  end

  assign rom_addr    = cur_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = op_q;
  assign alu_valid   = alu_valid_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_idx     = res_idx_q;
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Bench for fpu_op_sequencer: operand-store and FP ALU models plus a result scoreboard
// filled when each batch is launched and drained as res_valid pulses arrive.
module tb_fpu_op_sequencer;

  localparam int IDX_W = 4;
  localparam int TO_W  = 5;
  localparam int DEPTH = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [IDX_W-1:0] first_idx;
  logic [IDX_W-1:0] num_ops;
  logic [1:0]       op_sel;
  logic [IDX_W-1:0] rom_addr;
  logic [31:0]      rom_a;
  logic [31:0]      rom_b;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [1:0]       alu_op;
  logic             alu_valid;
  logic             alu_ready;
  logic             alu_res_valid;
  logic [31:0]      alu_res;
  logic             res_valid;
  logic [31:0]      res_data;
  logic [IDX_W-1:0] res_idx;
  logic             busy;
  logic             done;
  logic             timeout_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] mem_a [DEPTH];
  logic [31:0] mem_b [DEPTH];

  int               iss_q[$];
  logic [IDX_W-1:0] res_idx_exp[$];
  logic [31:0]      res_dat_exp[$];
  logic [1:0]       exp_op = 2'b00;

  int ready_delay = 0;
  int res_delay   = 3;
  bit res_enable  = 1'b1;
  int hs_count    = 0;
  int hs_cyc      = 0;
  int res_seen    = 0;

  fpu_op_sequencer #(.IDX_W(IDX_W), .TO_W(TO_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .first_idx(first_idx), .num_ops(num_ops),
    .op_sel(op_sel), .rom_addr(rom_addr), .rom_a(rom_a), .rom_b(rom_b), .alu_a(alu_a),
    .alu_b(alu_b), .alu_op(alu_op), .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_res_valid(alu_res_valid), .alu_res(alu_res), .res_valid(res_valid),
    .res_data(res_data), .res_idx(res_idx), .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous operand store: data follows the address by one clock.
  always @(posedge clk) begin
    rom_a <= mem_a[rom_addr];
    rom_b <= mem_b[rom_addr];
  end

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] op);
    return a ^ {b[15:0], b[31:16]} ^ {30'd0, op};
  endfunction

  // ALU model: holds off alu_ready for ready_delay cycles, then answers res_delay cycles
  // after the handshake. Operands are compared against the store on every cycle they are offered.
  initial begin : alu_model
    int          ready_wait;
    int          res_wait;
    bit          res_pending;
    logic [31:0] pend_res;
    int          idx;
    ready_wait    = 0;
    res_wait      = 0;
    res_pending   = 1'b0;
    pend_res      = '0;
    alu_ready     = 1'b0;
    alu_res_valid = 1'b0;
    alu_res       = '0;
    forever begin
      @(negedge clk);
      alu_res_valid = 1'b0;
      alu_ready     = 1'b0;
      if (res_pending) begin
        res_wait--;
        if (res_wait <= 0) begin
          alu_res_valid = 1'b1;
          alu_res       = pend_res;
          res_pending   = 1'b0;
        end
      end
      if (rst_n && alu_valid) begin
        checks++;
        if (iss_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_issue: alu_valid=1 with alu_a=%h, required no issue", alu_a);
        end else begin
          idx = iss_q[0];
          if (alu_a !== mem_a[idx] || alu_b !== mem_b[idx] || alu_op !== exp_op) begin
            errors++;
            $display("[TB] FAIL operands idx %0d: got a=%h b=%h op=%b, required a=%h b=%h op=%b",
                     idx, alu_a, alu_b, alu_op, mem_a[idx], mem_b[idx], exp_op);
          end
          if (ready_wait >= ready_delay) begin
            alu_ready  = 1'b1;
            ready_wait = 0;
            void'(iss_q.pop_front());
            hs_count++;
            hs_cyc = cyc + 1;
            if (res_enable) begin
              res_pending = 1'b1;
              res_wait    = res_delay;
              pend_res    = alu_fn(alu_a, alu_b, alu_op);
            end
          end else begin
            ready_wait++;
          end
        end
      end
    end
  end

  // Result scoreboard drain.
  initial begin : res_monitor
    logic [IDX_W-1:0] ei;
    logic [31:0]      ed;
    forever begin
      @(negedge clk);
      if (res_valid) begin
        res_seen++;
        checks++;
        if (res_idx_exp.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_result: got idx=%0d data=%h, required no result",
                   res_idx, res_data);
        end else begin
          ei = res_idx_exp.pop_front();
          ed = res_dat_exp.pop_front();
          if (res_idx !== ei || res_data !== ed) begin
            errors++;
            $display("[TB] FAIL result: got idx=%0d data=%h, required idx=%0d data=%h",
                     res_idx, res_data, ei, ed);
          end
        end
      end
    end
  end

  task automatic flush_expectations();
    iss_q.delete();
    res_idx_exp.delete();
    res_dat_exp.delete();
  endtask

  // Drives one start pulse and records the expected issue/result sequence for the batch.
  task automatic launch(input int first, input int num, input logic [1:0] op);
    logic [IDX_W-1:0] idx;
    @(negedge clk);
    first_idx = first[IDX_W-1:0];
    num_ops   = num[IDX_W-1:0];
    op_sel    = op;
    exp_op    = op;
    for (int i = 0; i <= num; i++) begin
      idx = IDX_W'((first + i) % DEPTH);
      iss_q.push_back(int'(idx));
      res_idx_exp.push_back(idx);
      res_dat_exp.push_back(alu_fn(mem_a[idx], mem_b[idx], op));
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string name);
    int n;
    n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL %s_done: done=%b after %0d cycles, required 1", name, done, limit);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({alu_valid, res_valid, busy, done, timeout_err} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags_held: got %b, required 00000",
               {alu_valid, res_valid, busy, done, timeout_err});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({alu_a, alu_b, res_data} !== 96'b0) begin
      errors++;
      $display("[TB] FAIL reset_data: got a=%h b=%h res=%h, required all 0", alu_a, alu_b, res_data);
    end
    checks++;
    if ({rom_addr, res_idx, alu_op} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_idx: got addr=%0d res_idx=%0d op=%b, required 0",
               rom_addr, res_idx, alu_op);
    end
    checks++;
    if ({alu_valid, res_valid, busy, done, timeout_err} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b, required 00000",
               {alu_valid, res_valid, busy, done, timeout_err});
    end
  endtask

  task automatic test_single_op();
    int r0;
    int h0;
    ready_delay = 0;
    res_delay   = 3;
    res_enable  = 1'b1;
    r0 = res_seen;
    h0 = hs_count;
    launch(0, 0, 2'b00);
    checks++;
    if (busy !== 1'b1 || alu_valid !== 1'b0 || rom_addr !== 4'd0) begin
      errors++;
      $display("[TB] FAIL single_fetch: got busy=%b valid=%b addr=%0d, required 1 0 0",
               busy, alu_valid, rom_addr);
    end
    @(negedge clk);
    checks++;
    if (alu_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_latency_early: alu_valid=%b one cycle after accept, required 0",
               alu_valid);
    end
    @(negedge clk);
    checks++;
    if (alu_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_latency: alu_valid=%b two cycles after accept, required 1",
               alu_valid);
    end
    wait_done(30, "single");
    checks++;
    if (res_seen - r0 != 1 || hs_count - h0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_counts: got results=%0d issues=%0d busy=%b, required 1 1 0",
               res_seen - r0, hs_count - h0, busy);
    end
  endtask

  task automatic test_backpressure_wrap();
    int r0;
    ready_delay = 4;
    res_delay   = 2;
    res_enable  = 1'b1;
    r0 = res_seen;
    launch(14, 3, 2'b10);
    wait_done(200, "wrap");
    checks++;
    if (res_seen - r0 != 4 || res_idx_exp.size() != 0) begin
      errors++;
      $display("[TB] FAIL wrap_counts: got results=%0d left=%0d, required 4 0",
               res_seen - r0, res_idx_exp.size());
    end
  endtask

  task automatic test_timeout();
    int n;
    int r0;
    ready_delay = 0;
    res_enable  = 1'b0;
    launch(4, 1, 2'b11);
    n = 0;
    while (!timeout_err && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (timeout_err !== 1'b1 || cyc - hs_cyc != 31) begin
      errors++;
      $display("[TB] FAIL timeout_time: err=%b after %0d cycles in wait, required 1 after 31",
               timeout_err, cyc - hs_cyc);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_state: got done=%b busy=%b, required 1 0", done, busy);
    end
    flush_expectations();
    res_enable = 1'b1;
    res_delay  = 3;
    r0 = res_seen;
    launch(6, 0, 2'b01);
    checks++;
    if (timeout_err !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_clear: got err=%b done=%b busy=%b, required 0 0 1",
               timeout_err, done, busy);
    end
    wait_done(30, "after_timeout");
    checks++;
    if (res_seen - r0 != 1 || timeout_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL after_timeout: got results=%0d err=%b, required 1 0",
               res_seen - r0, timeout_err);
    end
  endtask

  task automatic test_start_ignored();
    int r0;
    ready_delay = 1;
    res_delay   = 2;
    res_enable  = 1'b1;
    r0 = res_seen;
    launch(3, 2, 2'b01);
    repeat (2) @(negedge clk);
    first_idx = 4'd9;
    num_ops   = 4'd0;
    op_sel    = 2'b11;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ignored_busy: got busy=%b, required 1", busy);
    end
    wait_done(100, "ignored");
    checks++;
    if (res_seen - r0 != 3 || res_idx_exp.size() != 0) begin
      errors++;
      $display("[TB] FAIL ignored_counts: got results=%0d left=%0d, required 3 0",
               res_seen - r0, res_idx_exp.size());
    end
  endtask

  task automatic test_reset_mid_batch();
    int r0;
    int h0;
    int n;
    ready_delay = 0;
    res_delay   = 6;
    res_enable  = 1'b1;
    h0 = hs_count;
    launch(5, 1, 2'b00);
    n = 0;
    while (hs_count == h0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({alu_valid, res_valid, busy, done} !== 4'b0) begin
      errors++;
      $display("[TB] FAIL midreset_async: got valid=%b res_valid=%b busy=%b done=%b, required 0",
               alu_valid, res_valid, busy, done);
    end
    flush_expectations();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    r0 = res_seen;
    repeat (10) @(negedge clk);
    checks++;
    if (res_seen != r0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_quiet: got results=%0d busy=%b, required 0 0",
               res_seen - r0, busy);
    end
    res_delay = 3;
    r0 = res_seen;
    launch(2, 1, 2'b10);
    wait_done(60, "post_reset");
    checks++;
    if (res_seen - r0 != 2 || res_idx_exp.size() != 0) begin
      errors++;
      $display("[TB] FAIL post_reset_counts: got results=%0d left=%0d, required 2 0",
               res_seen - r0, res_idx_exp.size());
    end
  endtask

  initial begin : main
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = 32'h3F80_0000 + 32'(i) * 32'h0013_5791;
      mem_b[i] = 32'h4100_0000 ^ (32'(i) * 32'h0246_8ACE);
    end
    start     = 1'b0;
    first_idx = '0;
    num_ops   = '0;
    op_sel    = '0;
    rst_n     = 1'b1;
    #1;
    test_reset();
    test_single_op();
    test_backpressure_wrap();
    test_timeout();
    test_start_ignored();
    test_reset_mid_batch();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : global_limit
    #500000;
    $display("[TB] FAIL global_timeout: simulation still running at 500000, required finish");
    $fatal(1, "[TB] aborted");
  end

endmodule
